// File: rtl/uart_rx_servo_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default line timing.
package uart_rx_servo_pkg;

  localparam int unsigned DefaultClkHz = 50_000_000;
  localparam int unsigned DefaultBaud  = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Bits needed to hold div-1 in the bit-period down-counter.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_servo_bit_timer.sv
// Loadable down-counter that parks at zero; expired_o is high while the count is zero.
module uart_rx_servo_bit_timer #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_servo.sv
// 8N1 UART receiver feeding a servo position register; mid-bit sampling with frame-error and break handling.
module uart_rx_servo
  import uart_rx_servo_pkg::*;
#(
  parameter int unsigned ClkFrequency = DefaultClkHz,
  parameter int unsigned Baud         = DefaultBaud,
  parameter int unsigned BitDiv       = ClkFrequency / Baud
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_error,
  output logic       RxD_busy
);

  localparam int unsigned CntW = cnt_width(BitDiv);
  localparam logic [CntW-1:0] HalfLoad = CntW'(BitDiv / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(BitDiv - 1);

  logic            sync_q;
  logic            rx_s_q;
  uart_state_e     state_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            ready_q;
  logic            ferr_q;

  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_expired;

  // Synchronizer resets to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= RxD;
      rx_s_q <= sync_q;
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = FullLoad;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          tmr_load = 1'b1;
          tmr_val  = HalfLoad;
        end
      end
      ST_START: tmr_load = tmr_expired && !rx_s_q;
      ST_DATA:  tmr_load = tmr_expired;
      default:  tmr_load = 1'b0;
    endcase
  end

  uart_rx_servo_bit_timer #(
    .Width(CntW)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_expired)
  );

  // Output contract: RxD_data is a held register; ready and frame_error are one-clock
  // strobes with no backpressure, mutually exclusive, never on consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tmr_expired) begin
            if (!rx_s_q) begin
              bit_idx_q <= 3'd0;
              state_q   <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tmr_expired) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tmr_expired) begin
            if (rx_s_q) begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RxD_data        = data_q;
  assign RxD_data_ready  = ready_q;
  assign RxD_frame_error = ferr_q;
  assign RxD_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_servo.sv
// Bench for uart_rx_servo: directed and random 8N1 frames against a queue of expected receive events.
module tb_uart_rx_servo;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 100_000;
  localparam int BIT_DIV = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_error;
  logic       RxD_busy;

  uart_rx_servo #(
    .ClkFrequency(CLK_HZ),
    .Baud        (BAUD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .RxD            (rxd),
    .RxD_data       (RxD_data),
    .RxD_data_ready (RxD_data_ready),
    .RxD_frame_error(RxD_frame_error),
    .RxD_busy       (RxD_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard: bit 8 set means a framing error is expected instead of a byte
  logic [8:0] exp_q[$];
  int         mid_q[$];
  logic [7:0] model_data;
  logic       prev_strobe;
  logic [8:0] ev;
  int         mid;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_ready = 0;
  int         n_ferr = 0;
  int         n_ok_sent = 0;
  int         n_err_sent = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: all input changes happen 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(BIT_DIV);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (stop_ok) begin
      exp_q.push_back({1'b0, d});
      n_ok_sent++;
    end else begin
      exp_q.push_back({1'b1, 8'h00});
      n_err_sent++;
    end
    mid_q.push_back(cyc + BIT_DIV / 2);
    send_bit(stop_ok);
    if (stop_ok) check("busy_between_frames", RxD_busy, 1'b0);
  endtask

  // Monitor: strobe rules, event order, latency, and data hold
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (RxD_data_ready || RxD_frame_error) begin
        check("strobe_exclusive", RxD_data_ready & RxD_frame_error, 1'b0);
        check("strobe_single_cycle", prev_strobe, 1'b0);
        check("pending_event", exp_q.size() > 0, 1'b1);
        if (RxD_data_ready) n_ready++;
        if (RxD_frame_error) n_ferr++;
        if (exp_q.size() > 0) begin
          ev  = exp_q.pop_front();
          mid = mid_q.pop_front();
          check("strobe_kind", RxD_frame_error, ev[8]);
          if (!ev[8]) model_data = ev[7:0];
          check("strobe_latency", (cyc - mid >= 0) && (cyc - mid <= BIT_DIV + 2), 1'b1);
        end
      end
      check("data_hold", RxD_data, model_data);
    end
    prev_strobe = RxD_data_ready | RxD_frame_error;
  end

  int         base_ready;
  int         base_ferr;
  logic [7:0] rb;
  logic       rok;
  logic [7:0] v81;

  initial begin
    rst_n       = 1'b0;
    rxd         = 1'b1;
    model_data  = 8'h00;
    prev_strobe = 1'b0;
    tick(3);
    check("rst_data", RxD_data, 8'h00);
    check("rst_ready", RxD_data_ready, 1'b0);
    check("rst_ferr", RxD_frame_error, 1'b0);
    check("rst_busy", RxD_busy, 1'b0);
    rst_n = 1'b1;
    tick(5);
    check("idle_busy", RxD_busy, 1'b0);

    // Single byte with a good stop bit
    send_byte(8'hA5, 1'b1);
    tick(3);
    check("a5_data", RxD_data, 8'hA5);
    check("a5_ready_count", n_ready, 1);

    // Back-to-back frames, no idle gap
    base_ready = n_ready;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(3);
    check("b2b_data", RxD_data, 8'hFF);
    check("b2b_ready_count", n_ready - base_ready, 2);
    check("b2b_ferr_count", n_ferr, 0);

    // Short low glitch while idle
    base_ready = n_ready;
    rxd = 1'b0;
    tick(5);
    check("glitch_busy_high", RxD_busy, 1'b1);
    rxd = 1'b1;
    tick(3 * BIT_DIV);
    check("glitch_busy_low", RxD_busy, 1'b0);
    check("glitch_no_ready", n_ready - base_ready, 0);
    check("glitch_no_ferr", n_ferr, 0);
    check("glitch_data", RxD_data, 8'hFF);

    // Low stop bit followed by a long break
    send_byte(8'h3C, 1'b0);
    tick(2000);
    check("break_busy_high", RxD_busy, 1'b1);
    check("break_ferr_count", n_ferr, 1);
    check("break_data_kept", RxD_data, 8'hFF);
    rxd = 1'b1;
    tick(5);
    check("break_release_busy", RxD_busy, 1'b0);

    // Reset in the middle of the 4th data bit of 0x81
    base_ready = n_ready;
    v81 = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(v81[i]);
    rxd = v81[3];
    tick(BIT_DIV / 2);
    check("midframe_busy", RxD_busy, 1'b1);
    rst_n      = 1'b0;
    rxd        = 1'b1;
    model_data = 8'h00;
    tick(2);
    check("midrst_data", RxD_data, 8'h00);
    check("midrst_ready", RxD_data_ready, 1'b0);
    check("midrst_ferr", RxD_frame_error, 1'b0);
    check("midrst_busy", RxD_busy, 1'b0);
    rst_n = 1'b1;
    tick(2 * BIT_DIV);
    send_byte(8'h42, 1'b1);
    tick(3);
    check("post_rst_data", RxD_data, 8'h42);
    check("post_rst_ready_count", n_ready - base_ready, 1);

    // Sweep every byte value with small random gaps
    for (int v = 0; v < 256; v++) begin
      send_byte(8'(v), 1'b1);
      tick($urandom_range(0, 3));
    end

    // Random frames, occasionally with a bad stop bit and a random break length
    for (int k = 0; k < 40; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 7) != 0);
      send_byte(rb, rok);
      if (!rok) begin
        tick($urandom_range(0, 30));
        rxd = 1'b1;
        tick(4);
      end
      tick($urandom_range(0, 5));
    end

    tick(3 * BIT_DIV);
    check("all_events_seen", exp_q.size(), 0);
    check("total_ready", n_ready, n_ok_sent);
    check("total_ferr", n_ferr, n_err_sent);
    check("final_busy", RxD_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_servo.md
UART_RX_SERVO -- requirements
Module: uart_rx_servo

Interface
REQ-001 The block SHALL have parameter ClkFrequency, default 50000000, system clock in Hz.
REQ-002 The block SHALL have parameter Baud, default 115200, serial bit rate.
REQ-003 The block SHALL have parameter BitDiv, default ClkFrequency/Baud (434), clocks per bit, integer-truncated.
REQ-004 The block SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-005 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port RxD, input, 1, asynchronous serial line, idle high, 8N1 LSB-first.
REQ-007 The block SHALL have port RxD_data, output, 8, last correctly framed byte; feeds the servo pulse generator's position input.
REQ-008 The block SHALL have port RxD_data_ready, output, 1, one-clock strobe when RxD_data updates.
REQ-009 The block SHALL have port RxD_frame_error, output, 1, one-clock strobe when a stop bit samples low.
REQ-010 The block SHALL have port RxD_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 RxD SHALL pass through a 2-flop synchronizer; all decisions use the second flop (rx_s), giving 2 clocks of input latency.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: on rx_s==0, load bit counter with BitDiv/2-1 (216) and go to START.
REQ-014 START: when counter reaches 0, if rx_s==0 reload BitDiv-1 (433), clear bit index and go to DATA; if rx_s==1 (glitch) return to IDLE with no strobe.
REQ-015 DATA: at each counter expiry, shift rx_s into shift register MSB (right shift, LSB first), reload 433, increment 3-bit index; after the 8th sample (index wraps 7->0) go to STOP.
REQ-016 STOP: at counter expiry, if rx_s==1, load RxD_data from the shift register, pulse RxD_data_ready for exactly one clock and go to IDLE.
REQ-017 STOP: at counter expiry, if rx_s==0, pulse RxD_frame_error for one clock, leave RxD_data unchanged and go to BREAK.
REQ-018 BREAK: remain until rx_s==1, then go to IDLE; no new start SHALL be detected while in BREAK.
REQ-019 The counter SHALL be wide enough for BitDiv-1 (9 bits at defaults) and SHALL decrement by 1 per clock, never wrapping below 0.
REQ-020 RxD_data_ready and RxD_frame_error SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-021 RxD_data SHALL hold its value between strobes, so a downstream sampler may read it at any time.
REQ-022 A start edge arriving in the same cycle as the STOP-to-IDLE transition SHALL be detected on the following cycle (IDLE evaluates rx_s every cycle).

Reset
REQ-023 While rst_n==0 at posedge clk: state=IDLE, counter=0, index=0, shift register=0, RxD_data=8'h00, both strobes=0, RxD_busy=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no strobe; after release, reception SHALL resume at the next falling edge.

Structure
REQ-025 The FSM state encoding and the default ClkFrequency/Baud constants SHALL live in the shared project package, for reuse by a future transmitter.
REQ-026 A sub-module, bit_timer (loadable down-counter with expiry flag), is natural; it is optional, and inlining it is permitted.

Verification
REQ-027 Byte 8'hA5 at 115200 baud, valid stop -> RxD_data==8'hA5, with a single-cycle RxD_data_ready strobe within 436 clocks of the stop-bit midpoint.
REQ-028 Back-to-back bytes 8'h00, 8'hFF with no idle gap -> two ready strobes and data 8'h00 then 8'hFF, with no frame error.
REQ-029 A 100-clock low glitch on RxD while idle -> return to IDLE, no strobes, and RxD_data unchanged.
REQ-030 Byte 8'h3C with a low stop bit, line held low for 2000 clocks -> one RxD_frame_error strobe, RxD_data unchanged, RxD_busy high until the line returns high.
REQ-031 Reset during the 4th data bit of 8'h81, then a clean frame of 8'h42 -> only 8'h42 reported, and all outputs at reset values during reset.
REQ-032 Sweep 8'h00..8'hFF -> every byte received exactly, with RxD_busy low between frames.
